// File: rtl/wb_dsp_vector_reader.sv
// Wishbone master that drains a circular sample buffer. It fetches the buffer
// descriptor, reads samples from the read pointer up to a snapshot of the
// write pointer (or up to a requested count), hands each sample to the DSP
// engine over a valid/ready handshake, then writes the read pointer back.
//
// Optional feature macro: WB_DSP_READER_CLEAR_EN
//   When defined, every consumed sample word is overwritten with zero
//   (state S_CLEAR) before the read pointer advances.
//
// Handshake: a sample transfers on the rising clock edge where sample_valid
// and sample_ready are both high. sample_data and sample_valid stay stable
// while sample_valid is high and sample_ready is low.
module wb_dsp_vector_reader #(
    parameter int              dw            = 32,
    parameter int              aw            = 32,
    parameter logic [aw-1:0]   WR_PTR_OFFSET = 'h00,
    parameter logic [aw-1:0]   START_OFFSET  = 'h04,
    parameter logic [aw-1:0]   END_OFFSET    = 'h08,
    parameter logic [aw-1:0]   RD_PTR_OFFSET = 'h0C,
    parameter int              RETRY_LIMIT   = 3
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i,
    input  logic          start,
    input  logic [aw-1:0] base_address,
    input  logic [15:0]   count,
    output logic [dw-1:0] sample_data,
    output logic          sample_valid,
    input  logic          sample_ready,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam int             RW        = $clog2(RETRY_LIMIT + 2);
    localparam logic [RW-1:0]  RETRY_MAX = RW'(RETRY_LIMIT);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH_WR,
        S_FETCH_RD,
        S_FETCH_START,
        S_FETCH_END,
        S_CHECK,
        S_READ_DATA,
        S_PRESENT,
        S_ADVANCE,
`ifdef WB_DSP_READER_CLEAR_EN
        S_CLEAR,
`endif
        S_WRITE_RD,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [aw-1:0]   base;
    logic [aw-1:0]   wr_ptr;
    logic [aw-1:0]   rd_ptr;
    logic [aw-1:0]   start_ptr;
    logic [aw-1:0]   end_ptr;
    logic [15:0]     cnt_lim;
    logic [15:0]     remaining;
    logic [RW-1:0]   retry_cnt;

    // Access requested by the current state (address, direction, data)
    logic            acc_req;
    logic [aw-1:0]   acc_adr;
    logic            acc_we;
    logic [dw-1:0]   acc_dat;

    // Termination of the outstanding access, ack has priority over err/rty
    logic            bus_ack;
    logic            bus_err;
    logic            bus_rty;
    logic [aw-1:0]   rd_inc;
    logic            pass_end;

    assign bus_ack  = wb_cyc_o & wb_ack_i;
    assign bus_err  = wb_cyc_o & ~wb_ack_i &
                      (wb_err_i | (wb_rty_i & (retry_cnt >= RETRY_MAX)));
    assign bus_rty  = wb_cyc_o & ~wb_ack_i & ~wb_err_i & wb_rty_i &
                      (retry_cnt < RETRY_MAX);
    assign rd_inc   = rd_ptr + aw'(4);
    assign pass_end = (rd_ptr == wr_ptr) || ((cnt_lim != 16'd0) && (remaining == 16'd0));

    assign wb_cti_o = 3'b000;
    assign wb_bte_o = 2'b00;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign error    = (state == S_ERROR);

    // State register
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic and per-state bus access selection
    always_comb begin
        next_state = state;
        acc_req    = 1'b0;
        acc_adr    = '0;
        acc_we     = 1'b0;
        acc_dat    = '0;
        unique case (state)
            S_IDLE: begin
                if (start) next_state = S_FETCH_WR;
            end
            S_FETCH_WR: begin
                acc_req = 1'b1;
                acc_adr = base + WR_PTR_OFFSET;
                if (bus_err)      next_state = S_ERROR;
                else if (bus_ack) next_state = S_FETCH_RD;
            end
            S_FETCH_RD: begin
                acc_req = 1'b1;
                acc_adr = base + RD_PTR_OFFSET;
                if (bus_err)      next_state = S_ERROR;
                else if (bus_ack) next_state = S_FETCH_START;
            end
            S_FETCH_START: begin
                acc_req = 1'b1;
                acc_adr = base + START_OFFSET;
                if (bus_err)      next_state = S_ERROR;
                else if (bus_ack) next_state = S_FETCH_END;
            end
            S_FETCH_END: begin
                acc_req = 1'b1;
                acc_adr = base + END_OFFSET;
                if (bus_err)      next_state = S_ERROR;
                else if (bus_ack) next_state = S_CHECK;
            end
            S_CHECK: begin
                if (pass_end) next_state = S_WRITE_RD;
                else          next_state = S_READ_DATA;
            end
            S_READ_DATA: begin
                acc_req = 1'b1;
                acc_adr = rd_ptr;
                if (bus_err)      next_state = S_ERROR;
                else if (bus_ack) next_state = S_PRESENT;
            end
            S_PRESENT: begin
                if (sample_ready) begin
`ifdef WB_DSP_READER_CLEAR_EN
                    next_state = S_CLEAR;
`else
                    next_state = S_ADVANCE;
`endif
                end
            end
`ifdef WB_DSP_READER_CLEAR_EN
            S_CLEAR: begin
                acc_req = 1'b1;
                acc_adr = rd_ptr;
                acc_we  = 1'b1;
                acc_dat = '0;
                if (bus_err)      next_state = S_ERROR;
                else if (bus_ack) next_state = S_ADVANCE;
            end
`endif
            S_ADVANCE: begin
                next_state = S_CHECK;
            end
            S_WRITE_RD: begin
                acc_req = 1'b1;
                acc_adr = base + RD_PTR_OFFSET;
                acc_we  = 1'b1;
                acc_dat = dw'(rd_ptr);
                if (bus_err)      next_state = S_ERROR;
                else if (bus_ack) next_state = S_DONE;
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            S_ERROR: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Wishbone master: issue when idle on the bus, drop on any termination.
    // A retry drops cyc for one cycle; the same state then reissues it.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= 4'h0;
            retry_cnt <= '0;
        end else begin
            if (wb_cyc_o) begin
                if (bus_ack || bus_err || bus_rty) begin
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    wb_we_o  <= 1'b0;
                    wb_sel_o <= 4'h0;
                end
            end else if (acc_req) begin
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_we_o  <= acc_we;
                wb_adr_o <= acc_adr;
                wb_dat_o <= acc_dat;
                wb_sel_o <= 4'hF;
            end
            if (bus_rty)                     retry_cnt <= retry_cnt + RW'(1);
            else if (bus_ack || bus_err)     retry_cnt <= '0;
            else if (state == S_IDLE)        retry_cnt <= '0;
        end
    end

    // Pass context, descriptor capture and read-pointer advance
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            base      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            start_ptr <= '0;
            end_ptr   <= '0;
            cnt_lim   <= '0;
            remaining <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        base      <= base_address;
                        cnt_lim   <= count;
                        remaining <= count;
                    end
                end
                S_FETCH_WR:    if (bus_ack) wr_ptr    <= aw'(wb_dat_i);
                S_FETCH_RD:    if (bus_ack) rd_ptr    <= aw'(wb_dat_i);
                S_FETCH_START: if (bus_ack) start_ptr <= aw'(wb_dat_i);
                S_FETCH_END:   if (bus_ack) end_ptr   <= aw'(wb_dat_i);
                S_ADVANCE: begin
                    rd_ptr <= (rd_inc > end_ptr) ? start_ptr : rd_inc;
                    if (cnt_lim != 16'd0) remaining <= remaining - 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Sample output register toward the DSP engine
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
        end else begin
            if ((state == S_READ_DATA) && bus_ack) begin
                sample_data  <= wb_dat_i;
                sample_valid <= 1'b1;
            end else if ((state == S_PRESENT) && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_dsp_vector_reader.sv
// Bench for wb_dsp_vector_reader: zero-wait memory slave with retry/error/hold
// injection, a pass-level model of the bus accesses and samples, and a
// per-cycle compare process.
module tb_wb_dsp_vector_reader;

    logic        clk;
    logic        rst;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;
    logic        start;
    logic [31:0] base_address;
    logic [15:0] count;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    // expected bus accesses (acked ones only) and expected samples
    logic [31:0] exp_adr[$];
    logic        exp_we[$];
    logic [31:0] exp_dat[$];
    logic [31:0] exp_q[$];

    // slave memory and fault injection
    logic [31:0] mem [0:1023];
    logic [31:0] flt_adr = 32'h0;
    int          rty_n = 0;
    int          rty_mark = 0;
    int          rty_seen = 0;
    logic        err_en = 1'b0;
    logic        hold = 1'b0;
    logic        rty_now;
    logic        hit;
    logic        flt_hit;

    // observation counters
    int          done_seen = 0;
    int          err_seen = 0;
    int          stall_seen = 0;
    logic        bp_mode = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic [31:0] prev_data = 32'h0;

    wb_dsp_vector_reader dut (
        .wb_clk       (clk),
        .wb_rst       (rst),
        .wb_adr_o     (wb_adr_o),
        .wb_dat_o     (wb_dat_o),
        .wb_sel_o     (wb_sel_o),
        .wb_we_o      (wb_we_o),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_cti_o     (wb_cti_o),
        .wb_bte_o     (wb_bte_o),
        .wb_dat_i     (wb_dat_i),
        .wb_ack_i     (wb_ack_i),
        .wb_err_i     (wb_err_i),
        .wb_rty_i     (wb_rty_i),
        .start        (start),
        .base_address (base_address),
        .count        (count),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // zero-wait slave
    assign hit      = wb_cyc_o && wb_stb_o;
    assign flt_hit  = hit && (wb_adr_o == flt_adr);
    assign rty_now  = flt_hit && !hold && ((rty_seen - rty_mark) < rty_n);
    assign wb_rty_i = rty_now;
    assign wb_err_i = flt_hit && !hold && err_en && !rty_now;
    assign wb_ack_i = hit && !(flt_hit && hold) && !rty_now && !wb_err_i;
    assign wb_dat_i = mem[wb_adr_o[11:2]];

    always @(posedge clk) if (rty_now) rty_seen <= rty_seen + 1;

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_acc(input logic [31:0] a, input logic w, input logic [31:0] d);
        exp_adr.push_back(a);
        exp_we.push_back(w);
        exp_dat.push_back(d);
    endtask

    // Pass model: descriptor fetches, samples between rd and the wr snapshot
    // (bounded by count), optional clears, then the pointer write-back.
    task automatic build_expect(input logic [31:0] base, input logic [31:0] wr,
                                input logic [31:0] rd, input logic [31:0] st,
                                input logic [31:0] en, input logic [15:0] cnt,
                                output logic [31:0] fin, output int n);
        logic [31:0] p;
        mem[widx(base)]      = wr;
        mem[widx(base + 4)]  = st;
        mem[widx(base + 8)]  = en;
        mem[widx(base + 12)] = rd;
        push_acc(base, 1'b0, 32'h0);
        push_acc(base + 12, 1'b0, 32'h0);
        push_acc(base + 4, 1'b0, 32'h0);
        push_acc(base + 8, 1'b0, 32'h0);
        p = rd;
        n = 0;
        while (p != wr && !(cnt != 16'd0 && n == int'(cnt)) && n < 64) begin
            push_acc(p, 1'b0, 32'h0);
            exp_q.push_back(mem[widx(p)]);
`ifdef WB_DSP_READER_CLEAR_EN
            push_acc(p, 1'b1, 32'h0);
`endif
            p = (p + 32'd4 > en) ? st : p + 32'd4;
            n++;
        end
        push_acc(base + 12, 1'b1, p);
        fin = p;
    endtask

    // keep only the first k acked accesses; no samples reach the DSP
    task automatic truncate_expect(input int k);
        while (exp_adr.size() > k) begin
            void'(exp_adr.pop_back());
            void'(exp_we.pop_back());
            void'(exp_dat.pop_back());
        end
        exp_q.delete();
    endtask

    task automatic flush_expect();
        exp_adr.delete();
        exp_we.delete();
        exp_dat.delete();
        exp_q.delete();
    endtask

    // one pass: pulse start, wait for idle, check termination and drain
    task automatic run_pass(input string nm, input logic [31:0] base, input logic [15:0] cnt,
                            input int exp_done, input int exp_err, input logic extra_start);
        int  d0;
        int  e0;
        logic idle;
        d0 = done_seen;
        e0 = err_seen;
        base_address = base;
        count = cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk({nm, "_busy_on_start"}, busy, 1'b1);
        if (extra_start) begin
            repeat (4) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        idle = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        chk({nm, "_reached_idle"}, idle, 1'b1);
        repeat (4) @(negedge clk);
        chk({nm, "_done_pulses"}, done_seen - d0, exp_done);
        chk({nm, "_error_pulses"}, err_seen - e0, exp_err);
        chk({nm, "_bus_left"}, exp_adr.size(), 0);
        chk({nm, "_samples_left"}, exp_q.size(), 0);
        chk({nm, "_busy_after"}, busy, 1'b0);
        flush_expect();
    endtask

    // ready driver: in backpressure mode each sample waits 5 cycles
    initial begin
        int hold_cnt;
        hold_cnt = 0;
        sample_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (bp_mode && sample_valid) begin
                if (hold_cnt < 5) begin
                    sample_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    sample_ready = 1'b1;
                end
            end else begin
                sample_ready = !bp_mode;
                hold_cnt = 0;
            end
        end
    end

    // compare process: bus accesses, samples, stability, pulses
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
                if (exp_adr.size() == 0) begin
                    chk("bus_unexpected_access", wb_adr_o, 32'hFFFF_FFFF);
                end else begin
                    logic [31:0] ea;
                    logic        ew;
                    logic [31:0] ed;
                    ea = exp_adr.pop_front();
                    ew = exp_we.pop_front();
                    ed = exp_dat.pop_front();
                    chk("bus_adr", wb_adr_o, ea);
                    chk("bus_we", wb_we_o, ew);
                    if (ew) chk("bus_wdata", wb_dat_o, ed);
                    chk("bus_sel", wb_sel_o, 4'hF);
                    chk("bus_cti_bte", {wb_cti_o, wb_bte_o}, 5'b0);
                end
            end
            if (sample_valid) begin
                chk("no_bus_while_presenting", wb_cyc_o, 1'b0);
                if (prev_valid && !prev_hs) chk("sample_stable", sample_data, prev_data);
                if (!sample_ready) stall_seen++;
            end
            if (sample_valid && sample_ready) begin
                if (exp_q.size() == 0) chk("sample_unexpected", sample_data, 32'hFFFF_FFFF);
                else                   chk("sample_data", sample_data, exp_q.pop_front());
            end
            if (done)  done_seen++;
            if (error) err_seen++;
            prev_valid = sample_valid;
            prev_hs    = sample_valid && sample_ready;
            prev_data  = sample_data;
        end
    end

    initial begin
        logic [31:0] fin;
        int          n;
        int          s0;
        logic        found;

        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | (i << 2);
        rst = 1'b1;
        start = 1'b0;
        base_address = 32'h0;
        count = 16'h0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cyc_stb", {wb_cyc_o, wb_stb_o}, 2'b00);
        chk("rst_busy_done_err", {busy, done, error}, 3'b000);
        chk("rst_sample_valid", sample_valid, 1'b0);
        chk("rst_adr", wb_adr_o, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // basic drain, plus a start pulse while busy that must be ignored
        build_expect(32'h100, 32'h20C, 32'h200, 32'h200, 32'h20C, 16'd0, fin, n);
        chk("model_basic_fin", fin, 32'h20C);
        chk("model_basic_n", n, 3);
        run_pass("basic", 32'h100, 16'd0, 1, 0, 1'b1);
        repeat (5) @(negedge clk);
        chk("ignored_start_stays_idle", busy, 1'b0);

        // wrap
        build_expect(32'h100, 32'h204, 32'h208, 32'h200, 32'h20C, 16'd0, fin, n);
        chk("model_wrap_fin", fin, 32'h204);
        chk("model_wrap_n", n, 3);
        run_pass("wrap", 32'h100, 16'd0, 1, 0, 1'b0);

        // count limit, then empty pass
        build_expect(32'h100, 32'h20C, 32'h200, 32'h200, 32'h20C, 16'd2, fin, n);
        chk("model_count_fin", fin, 32'h208);
        chk("model_count_n", n, 2);
        run_pass("count", 32'h100, 16'd2, 1, 0, 1'b0);
        build_expect(32'h100, 32'h208, 32'h208, 32'h200, 32'h20C, 16'd0, fin, n);
        chk("model_empty_n", n, 0);
        run_pass("empty", 32'h100, 16'd0, 1, 0, 1'b0);

        // backpressure: 5 stalled cycles per sample
        s0 = stall_seen;
        bp_mode = 1'b1;
        build_expect(32'h100, 32'h20C, 32'h200, 32'h200, 32'h20C, 16'd0, fin, n);
        run_pass("backpressure", 32'h100, 16'd0, 1, 0, 1'b0);
        bp_mode = 1'b0;
        chk("backpressure_stalls", stall_seen - s0, 15);

        // two retries on the read-pointer fetch: recovered
        flt_adr = 32'h10C; rty_n = 2; rty_mark = rty_seen; err_en = 1'b0;
        build_expect(32'h100, 32'h20C, 32'h200, 32'h200, 32'h20C, 16'd0, fin, n);
        run_pass("retry2", 32'h100, 16'd0, 1, 0, 1'b0);
        chk("retry2_count", rty_seen - rty_mark, 2);

        // four retries: treated as error after the write-pointer fetch
        rty_n = 4; rty_mark = rty_seen;
        build_expect(32'h100, 32'h20C, 32'h200, 32'h200, 32'h20C, 16'd0, fin, n);
        truncate_expect(1);
        run_pass("retry4", 32'h100, 16'd0, 0, 1, 1'b0);
        chk("retry4_count", rty_seen - rty_mark, 4);
        rty_n = 0;

        // bus error on the first sample read
        flt_adr = 32'h200; err_en = 1'b1;
        build_expect(32'h100, 32'h20C, 32'h200, 32'h200, 32'h20C, 16'd0, fin, n);
        truncate_expect(4);
        run_pass("read_err", 32'h100, 16'd0, 0, 1, 1'b0);
        err_en = 1'b0;

        // asynchronous reset while the sample read is outstanding
        flt_adr = 32'h200; hold = 1'b1;
        build_expect(32'h100, 32'h20C, 32'h200, 32'h200, 32'h20C, 16'd0, fin, n);
        base_address = 32'h100;
        count = 16'd0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wb_cyc_o && wb_adr_o == 32'h200) begin
                found = 1'b1;
                break;
            end
        end
        chk("async_reached_read", found, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("async_cyc_stb", {wb_cyc_o, wb_stb_o}, 2'b00);
        chk("async_busy_valid", {busy, sample_valid}, 2'b00);
        flush_expect();
        hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // recovery after reset
        build_expect(32'h100, 32'h20C, 32'h200, 32'h200, 32'h20C, 16'd0, fin, n);
        run_pass("after_reset", 32'h100, 16'd0, 1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
